// File: rtl/audio_pwm_playback_pkg.sv
// Shared definitions for the audio playback engine:
// modulator modes, unity gain and default sample width.
package audio_pwm_playback_pkg;

  typedef enum logic {
    MODE_PWM = 1'b0,
    MODE_DSM = 1'b1
  } mode_e;

  localparam logic [8:0] VOL_UNITY = 9'd256;
  localparam int VOL_SHIFT = $clog2(VOL_UNITY);
  localparam int AUDIO_SAMPLE_W = 16;

endpackage

// File: rtl/sync_frame_fifo.sv
// Single-clock frame FIFO with occupancy count.
// Read data is the head entry, valid whenever not empty.
module sync_frame_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [W-1:0]               i_wdata,
  input  logic                       i_pop,
  output logic [W-1:0]               o_rdata,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;
  logic          w_full;

  assign w_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !w_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/audio_pwm_playback.sv
// Multi-channel playback: frame assembly, FIFO, sample ticks,
// volume with saturation and per-channel PWM / delta-sigma output.
module audio_pwm_playback
  import audio_pwm_playback_pkg::*;
#(
  parameter int NUM_CH          = 2,
  parameter int SAMPLE_W        = AUDIO_SAMPLE_W,
  parameter int PWM_W           = 10,
  parameter int FIFO_DEPTH      = 16,
  parameter int CLKS_PER_SAMPLE = 1024
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [SAMPLE_W-1:0]               s_data,
  input  logic                              s_valid,
  input  logic                              s_last,
  output logic                              s_ready,
  input  logic                              mode,
  input  logic [8:0]                        vol,
  input  logic                              clr_status,
  output logic [NUM_CH-1:0]                 pwm_out,
  output logic                              sample_tick,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              underrun,
  output logic                              sync_err
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int DIV_W = $clog2(CLKS_PER_SAMPLE);
  localparam int FW    = NUM_CH * SAMPLE_W;
  localparam int PW    = SAMPLE_W + 10;
  localparam int SH_W  = PW - VOL_SHIFT;
  localparam int SMAX_I = (2 ** (SAMPLE_W - 1)) - 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] DIV_TC   = DIV_W'(CLKS_PER_SAMPLE - 1);
  localparam logic [PWM_W-1:0] CNT_MAX  = '1;
  localparam logic [PWM_W-1:0] DUTY_MID = PWM_W'(2 ** (PWM_W - 1));
  localparam logic signed [SH_W-1:0] S_MAX = SH_W'(SMAX_I);
  localparam logic signed [SH_W-1:0] S_MIN = SH_W'(-SMAX_I - 1);

  logic [NUM_CH-1:0][SAMPLE_W-1:0] r_frame;
  logic [NUM_CH-1:0][SAMPLE_W-1:0] w_push_frame;
  logic [NUM_CH-1:0][SAMPLE_W-1:0] r_active;
  logic [FW-1:0]                   w_rdata;
  logic [IDX_W-1:0]                r_idx;
  logic [LVL_W-1:0]                w_level;
  logic [DIV_W-1:0]                r_div;
  logic [PWM_W-1:0]                r_cnt;
  mode_e                           r_mode;
  logic                            r_underrun;
  logic                            r_sync_err;
  logic                            w_empty;
  logic                            w_acc;
  logic                            w_at_last;
  logic                            w_discard;
  logic                            w_push;
  logic                            w_pop;
  logic                            w_tick;
  logic                            w_wrap;

  assign s_ready     = (w_level < LVL_FULL);
  assign fifo_level  = w_level;
  assign sample_tick = w_tick;
  assign underrun    = r_underrun;
  assign sync_err    = r_sync_err;

  assign w_acc     = s_valid && s_ready;
  assign w_at_last = (r_idx == LAST_IDX);
  assign w_discard = w_acc && s_last && !w_at_last;
  assign w_push    = w_acc && w_at_last;
  assign w_tick    = (r_div == DIV_TC);
  assign w_pop     = w_tick && !w_empty;
  assign w_wrap    = (r_cnt == CNT_MAX);

  // last channel word goes straight into the FIFO write data
  always_comb begin
    w_push_frame = r_frame;
    w_push_frame[NUM_CH-1] = s_data;
  end

  sync_frame_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (w_push_frame),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_count (w_level),
    .o_empty (w_empty)
  );

  // frame assembler: store word, advance or restart channel index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_frame <= '0;
    end else if (w_acc) begin
      r_frame[r_idx] <= s_data;
      if (w_discard || w_push) r_idx <= '0;
      else                     r_idx <= r_idx + IDX_W'(1);
    end
  end

  // sticky status; a new event beats a clear in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_underrun <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      if (w_tick && w_empty) r_underrun <= 1'b1;
      else if (clr_status)   r_underrun <= 1'b0;
      if (w_discard || (w_push && !s_last)) r_sync_err <= 1'b1;
      else if (clr_status)                  r_sync_err <= 1'b0;
    end
  end

  // sample-rate divider and frame release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div    <= '0;
      r_active <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + DIV_W'(1);
      if (w_pop) r_active <= w_rdata;
    end
  end

  // shared PWM counter; mode only changes at a period boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_mode <= MODE_PWM;
    end else begin
      r_cnt <= r_cnt + PWM_W'(1);
      if (w_wrap) r_mode <= mode_e'(mode);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic signed [PW-1:0]   w_a;
    logic signed [PW-1:0]   w_b;
    logic signed [PW-1:0]   w_prod;
    logic signed [SH_W-1:0] w_shift;
    logic [SAMPLE_W-1:0]    w_sat;
    logic [SAMPLE_W-1:0]    w_u;
    logic [PWM_W-1:0]       w_duty;
    logic [PWM_W-1:0]       r_duty;
    logic [SAMPLE_W:0]      r_acc;
    logic                   r_out;

    assign w_a     = PW'(signed'(r_active[g]));
    assign w_b     = PW'({1'b0, vol});
    assign w_prod  = w_a * w_b;
    assign w_shift = signed'(w_prod[PW-1:VOL_SHIFT]);

    // clamp scaled sample into the signed sample range
    always_comb begin
      w_sat = w_shift[SAMPLE_W-1:0];
      if (w_shift > S_MAX)
        w_sat = {1'b0, {(SAMPLE_W-1){1'b1}}};
      else if (w_shift < S_MIN)
        w_sat = {1'b1, {(SAMPLE_W-1){1'b0}}};
    end

    assign w_u    = {~w_sat[SAMPLE_W-1], w_sat[SAMPLE_W-2:0]};
    assign w_duty = w_u[SAMPLE_W-1 -: PWM_W];

    // duty latch, delta-sigma accumulator and output bit
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_duty <= DUTY_MID;
        r_acc  <= '0;
        r_out  <= 1'b0;
      end else begin
        if (w_wrap) r_duty <= w_duty;
        r_acc <= {1'b0, r_acc[SAMPLE_W-1:0]} + {1'b0, w_u};
        r_out <= (r_mode == MODE_DSM) ? r_acc[SAMPLE_W]
                                      : (r_cnt < r_duty);
      end
    end

    assign pwm_out[g] = r_out;
  end

endmodule

// File: tb/tb_audio_pwm_playback.sv
// Directed bench for audio_pwm_playback with small parameters.
// Expected values are hand-derived from the sample arithmetic.
module tb_audio_pwm_playback;
  import audio_pwm_playback_pkg::*;

  localparam int NCH = 2;
  localparam int SW  = 16;
  localparam int PWB = 4;
  localparam int FD  = 4;
  localparam int CPS = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [SW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic          mode = 1'b0;
  logic [8:0]    vol = VOL_UNITY;
  logic          clr_status = 1'b0;
  logic [NCH-1:0] pwm_out;
  logic          sample_tick;
  logic [2:0]    fifo_level;
  logic          underrun;
  logic          sync_err;

  int checks = 0;
  int failures = 0;
  int cl;
  int cr;
  int n;

  always #5 clk = ~clk;

  audio_pwm_playback #(
    .NUM_CH          (NCH),
    .SAMPLE_W        (SW),
    .PWM_W           (PWB),
    .FIFO_DEPTH      (FD),
    .CLKS_PER_SAMPLE (CPS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .mode        (mode),
    .vol         (vol),
    .clr_status  (clr_status),
    .pwm_out     (pwm_out),
    .sample_tick (sample_tick),
    .fifo_level  (fifo_level),
    .underrun    (underrun),
    .sync_err    (sync_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic word(input logic [SW-1:0] d, input logic l);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (sample_tick) seen = 1'b1;
    end
    if (!seen) chk("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic count_hi(input int cyc, output int l, output int r);
    l = 0;
    r = 0;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      l += int'(pwm_out[0]);
      r += int'(pwm_out[1]);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    word(16'h1111, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_pwm", 32'(pwm_out), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_sync", 32'(sync_err), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd1);
    chk("rst_tick", 32'(sample_tick), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    word(16'h7FFF, 1'b0);
    word(16'h8000, 1'b1);
    chk("post_rst_level", 32'(fifo_level), 32'd1);
    chk("post_rst_sync", 32'(sync_err), 32'd0);

    wait_tick();
    @(negedge clk);
    chk("pop_no_underrun", 32'(underrun), 32'd0);
    chk("pop_level", 32'(fifo_level), 32'd0);
    repeat (19) @(negedge clk);
    count_hi(16, cl, cr);
    chk("pwm_max_L", 32'(cl), 32'd15);
    chk("pwm_min_R", 32'(cr), 32'd0);
    chk("underrun_set", 32'(underrun), 32'd1);
    count_hi(16, cl, cr);
    chk("hold_L", 32'(cl), 32'd15);
    chk("hold_R", 32'(cr), 32'd0);

    wait_tick();
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    chk("set_beats_clr", 32'(underrun), 32'd1);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    @(negedge clk);
    chk("underrun_clr", 32'(underrun), 32'd0);

    word(16'h0000, 1'b0);
    word(16'h0000, 1'b1);
    wait_tick();
    repeat (20) @(negedge clk);
    count_hi(16, cl, cr);
    chk("mid_L", 32'(cl), 32'd8);
    chk("mid_R", 32'(cr), 32'd8);

    wait_tick();
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      word(16'(k * 2), 1'b0);
      word(16'(k * 2 + 1), 1'b1);
    end
    chk("bp_level_full", 32'(fifo_level), 32'd4);
    chk("bp_not_ready", 32'(s_ready), 32'd0);
    s_valid = 1'b1;
    s_data  = 16'h0AAA;
    s_last  = 1'b0;
    repeat (3) @(negedge clk);
    chk("bp_hold_level", 32'(fifo_level), 32'd4);
    wait_tick();
    @(negedge clk);
    chk("bp_after_tick_level", 32'(fifo_level), 32'd3);
    chk("bp_after_tick_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    word(16'h0BBB, 1'b1);
    chk("bp_fifth_frame", 32'(fifo_level), 32'd4);
    chk("bp_sync_ok", 32'(sync_err), 32'd0);

    repeat (4) wait_tick();
    @(negedge clk);
    chk("drain_level", 32'(fifo_level), 32'd0);

    wait_tick();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_tick && n < 100);
    chk("tick_period", 32'(n), 32'(CPS));

    @(negedge clk);
    chk("sync_clean", 32'(sync_err), 32'd0);
    word(16'h8000, 1'b1);
    chk("sync_early_last", 32'(sync_err), 32'd1);
    chk("sync_no_write", 32'(fifo_level), 32'd0);
    word(16'h4000, 1'b0);
    word(16'h0000, 1'b1);
    chk("sync_next_frame", 32'(fifo_level), 32'd1);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    chk("sync_clr", 32'(sync_err), 32'd0);
    word(16'h4000, 1'b0);
    word(16'h0000, 1'b0);
    chk("sync_missing_last", 32'(sync_err), 32'd1);
    chk("sync_missing_write", 32'(fifo_level), 32'd2);

    mode = MODE_DSM;
    wait_tick();
    repeat (40) @(negedge clk);
    count_hi(64, cl, cr);
    chk("dsm_L_3q", 32'(cl), 32'd48);
    chk("dsm_R_half", 32'(cr), 32'd32);

    mode = MODE_PWM;
    vol  = 9'd511;
    wait_tick();
    @(negedge clk);
    word(16'h7FFF, 1'b0);
    word(16'h8000, 1'b1);
    wait_tick();
    repeat (20) @(negedge clk);
    count_hi(16, cl, cr);
    chk("sat_pos_L", 32'(cl), 32'd15);
    chk("sat_neg_R", 32'(cr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
